// File: rtl/spike_infer_seq.sv
// Inference-window sequencer: clears per-class spike counters, accumulates output-neuron spikes for a
// programmed number of timesteps, then scans one class per cycle for the argmax and offers it on valid/ready.
module spike_infer_seq #(
  parameter int N_CLASSES = 10,
  parameter int CNT_W     = 8,
  parameter int WIN_W     = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic [WIN_W-1:0]     window_len_i,
  input  logic                 step_i,
  input  logic [N_CLASSES-1:0] spikes_i,
  output logic                 busy_o,
  output logic                 result_valid_o,
  input  logic                 result_ready_i,
  output logic [3:0]           predicted_digit_o,
  output logic [CNT_W-1:0]     max_count_o,
  output logic                 no_spike_o,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {IDLE, ACCUM, SCAN, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       LAST_IDX = 4'(N_CLASSES - 1);

  // Result handshake: result_valid_o rises on entry to DONE and the result fields stay frozen until the
  // cycle where result_valid_o & result_ready_i; the FSM returns to IDLE on the following edge.

  state_t             state;
  logic [CNT_W-1:0]   cnt [N_CLASSES];
  logic [WIN_W-1:0]   win_len;
  logic [WIN_W-1:0]   step_cnt;
  logic [3:0]         idx;
  logic [3:0]         run_digit;
  logic [CNT_W-1:0]   run_max;

  logic [CNT_W-1:0]   cur;
  logic               cur_gt;
  logic [CNT_W-1:0]   final_max;
  logic [3:0]         final_digit;

  // Strict compare keeps the earlier (lower) index on ties.
  always_comb begin
    cur         = cnt[idx];
    cur_gt      = (cur > run_max);
    final_max   = cur_gt ? cur : run_max;
    final_digit = cur_gt ? idx : run_digit;
  end

  assign dbg_state_o = state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state             <= IDLE;
      for (int k = 0; k < N_CLASSES; k++) cnt[k] <= '0;
      win_len           <= '0;
      step_cnt          <= '0;
      idx               <= '0;
      run_digit         <= '0;
      run_max           <= '0;
      busy_o            <= 1'b0;
      result_valid_o    <= 1'b0;
      predicted_digit_o <= '0;
      max_count_o       <= '0;
      no_spike_o        <= 1'b0;
    end else if (abort_i) begin
      state             <= IDLE;
      for (int k = 0; k < N_CLASSES; k++) cnt[k] <= '0;
      step_cnt          <= '0;
      idx               <= '0;
      run_digit         <= '0;
      run_max           <= '0;
      busy_o            <= 1'b0;
      result_valid_o    <= 1'b0;
      predicted_digit_o <= '0;
      max_count_o       <= '0;
      no_spike_o        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            for (int k = 0; k < N_CLASSES; k++) cnt[k] <= '0;
            win_len           <= window_len_i;
            step_cnt          <= '0;
            idx               <= '0;
            run_digit         <= '0;
            run_max           <= '0;
            busy_o            <= 1'b1;
            predicted_digit_o <= '0;
            max_count_o       <= '0;
            no_spike_o        <= 1'b0;
            state             <= (window_len_i == '0) ? SCAN : ACCUM;
          end
        end
        ACCUM: begin
          if (step_i) begin
            for (int k = 0; k < N_CLASSES; k++) begin
              if (spikes_i[k] && (cnt[k] != CNT_MAX)) cnt[k] <= cnt[k] + CNT_W'(1);
            end
            step_cnt <= step_cnt + WIN_W'(1);
            if ((step_cnt + WIN_W'(1)) == win_len) state <= SCAN;
          end
        end
        SCAN: begin
          if (cur_gt) begin
            run_max   <= cur;
            run_digit <= idx;
          end
          idx <= idx + 4'd1;
          if (idx == LAST_IDX) begin
            state             <= DONE;
            result_valid_o    <= 1'b1;
            max_count_o       <= final_max;
            no_spike_o        <= (final_max == '0);
            predicted_digit_o <= final_digit;
          end
        end
        DONE: begin
          if (result_ready_i) begin
            state          <= IDLE;
            result_valid_o <= 1'b0;
            busy_o         <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_infer_seq.sv
// Bench for spike_infer_seq: a window table driven through a scoreboard queue, plus hand sequences for
// backpressure, abort, reset mid-scan and counter saturation (a narrow-counter instance shares the inputs).
module tb_spike_infer_seq;

  localparam int N   = 10;
  localparam int CW  = 8;
  localparam int WW  = 8;
  localparam int SCW = 4;

  typedef logic [N-1:0] spk_t;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i, abort_i, step_i, result_ready_i;
  logic [WW-1:0] window_len_i;
  spk_t          spikes_i;

  logic          busy_o, result_valid_o, no_spike_o;
  logic [3:0]    predicted_digit_o;
  logic [CW-1:0] max_count_o;
  logic [1:0]    dbg_state_o;

  logic           s_busy, s_valid, s_no_spike;
  logic [3:0]     s_digit;
  logic [SCW-1:0] s_max;
  logic [1:0]     s_state;

  spike_infer_seq #(.N_CLASSES(N), .CNT_W(CW), .WIN_W(WW)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .window_len_i(window_len_i), .step_i(step_i), .spikes_i(spikes_i),
    .busy_o(busy_o), .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .predicted_digit_o(predicted_digit_o), .max_count_o(max_count_o),
    .no_spike_o(no_spike_o), .dbg_state_o(dbg_state_o)
  );

  spike_infer_seq #(.N_CLASSES(N), .CNT_W(SCW), .WIN_W(WW)) u_sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
    .window_len_i(window_len_i), .step_i(step_i), .spikes_i(spikes_i),
    .busy_o(s_busy), .result_valid_o(s_valid), .result_ready_i(result_ready_i),
    .predicted_digit_o(s_digit), .max_count_o(s_max),
    .no_spike_o(s_no_spike), .dbg_state_o(s_state)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [WW-1:0] len;
    spk_t          pat_a;
    int            cnt_a;
    spk_t          pat_b;
    int            cnt_b;
    logic [3:0]    digit;
    logic [CW-1:0] maxc;
    logic          ns;
  } vec_t;

  vec_t        vecs [8];
  vec_t        sat_vec;
  logic [12:0] exp_q [$];
  logic [12:0] last_exp;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [12:0] act_result();
    return {predicted_digit_o, max_count_o, no_spike_o};
  endfunction

  // driver: start, steps with random idle gaps (noise on spikes_i while step_i is low), wait for result
  task automatic drive_window(input vec_t v, input bit ack);
    int lat;
    exp_q.push_back({v.digit, v.maxc, v.ns});
    window_len_i = v.len;
    start_i      = 1'b1;
    tick();
    start_i      = 1'b0;
    window_len_i = WW'($urandom_range(0, 255));
    check("busy_after_start", busy_o, 1);
    check("outputs_zero_on_start", act_result(), 0);
    for (int i = 0; i < int'(v.len); i++) begin
      repeat ($urandom_range(0, 2)) begin
        spikes_i = spk_t'($urandom);
        tick();
      end
      spikes_i = ((i < v.cnt_a) ? v.pat_a : '0) | ((i < v.cnt_b) ? v.pat_b : '0);
      step_i   = 1'b1;
      tick();
      step_i   = 1'b0;
      spikes_i = spk_t'($urandom);
    end
    lat = 0;
    while (!result_valid_o && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", lat, N);
    check("result_valid", result_valid_o, 1);
    if (exp_q.size() > 0) begin
      last_exp = exp_q.pop_front();
      check("result", act_result(), last_exp);
    end
    if (ack) begin
      result_ready_i = 1'b1;
      tick();
      result_ready_i = 1'b0;
      check("valid_low_after_ack", result_valid_o, 0);
      check("idle_after_ack", {busy_o, dbg_state_o}, 0);
      check("result_held_in_idle", act_result(), last_exp);
    end
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    vecs[0] = '{8'd4, 10'h008, 4, 10'h080, 2, 4'd3, 8'd4, 1'b0};
    vecs[1] = '{8'd3, 10'h024, 3, 10'h000, 0, 4'd2, 8'd3, 1'b0};
    vecs[2] = '{8'd0, 10'h000, 0, 10'h000, 0, 4'd0, 8'd0, 1'b1};
    vecs[3] = '{8'd5, 10'h200, 5, 10'h001, 2, 4'd9, 8'd5, 1'b0};
    vecs[4] = '{8'd6, 10'h3FF, 6, 10'h000, 0, 4'd0, 8'd6, 1'b0};
    vecs[5] = '{8'd3, 10'h000, 0, 10'h000, 0, 4'd0, 8'd0, 1'b1};
    vecs[6] = '{8'd7, 10'h100, 3, 10'h010, 7, 4'd4, 8'd7, 1'b0};
    vecs[7] = '{8'd2, 10'h002, 2, 10'h040, 2, 4'd1, 8'd2, 1'b0};
    sat_vec = '{8'd255, 10'h200, 255, 10'h000, 0, 4'd9, 8'd255, 1'b0};

    rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; step_i = 1'b0;
    result_ready_i = 1'b0; window_len_i = '0; spikes_i = '0;
    repeat (2) tick();
    check("reset_outputs", {busy_o, result_valid_o, act_result(), dbg_state_o}, 0);
    rst_ni = 1'b1;
    tick();

    // steps while idle must not disturb anything
    step_i = 1'b1; spikes_i = '1;
    repeat (3) tick();
    step_i = 1'b0;
    check("idle_ignores_step", {busy_o, dbg_state_o}, 0);

    for (int t = 0; t < 8; t++) drive_window(vecs[t], 1'b1);

    // backpressure: result frozen for 20 cycles, start pulses ignored
    drive_window(vecs[0], 1'b0);
    for (int c = 0; c < 20; c++) begin
      start_i      = c[0];
      window_len_i = WW'($urandom_range(0, 255));
      tick();
      check("bp_valid", result_valid_o, 1);
      check("bp_result", act_result(), last_exp);
    end
    start_i = 1'b0;
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check("bp_release_valid", result_valid_o, 0);
    check("bp_release_state", dbg_state_o, 0);
    tick();
    check("bp_no_queued_start", busy_o, 0);

    // saturation: 255 steps on class 9, 8-bit and 4-bit counters
    drive_window(sat_vec, 1'b0);
    check("sat_narrow_valid", s_valid, 1);
    check("sat_narrow_result", {s_digit, s_max, s_no_spike}, {4'd9, 4'hF, 1'b0});
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;

    // abort mid-ACCUM
    window_len_i = 8'd8; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      spikes_i = 10'h010; step_i = 1'b1;
      tick();
    end
    step_i = 1'b0;
    check("accum_before_abort", dbg_state_o, 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort_idle", {busy_o, result_valid_o, dbg_state_o}, 0);
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step_i = 1'b1; spikes_i = spk_t'($urandom);
      tick();
      if (result_valid_o || busy_o) seen = 1'b1;
    end
    step_i = 1'b0;
    check("abort_no_result", seen, 0);
    drive_window(vecs[1], 1'b1);

    // reset asserted mid-SCAN
    window_len_i = 8'd2; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      spikes_i = 10'h020; step_i = 1'b1;
      tick();
    end
    step_i = 1'b0;
    repeat (3) tick();
    check("scan_before_reset", dbg_state_o, 2);
    rst_ni = 1'b0;
    #1;
    check("async_reset_outputs", {busy_o, result_valid_o, act_result(), dbg_state_o}, 0);
    #2;
    rst_ni = 1'b1;
    tick();
    seen = 1'b0;
    repeat (15) begin
      tick();
      if (result_valid_o) seen = 1'b1;
    end
    check("reset_no_partial", seen, 0);
    drive_window(vecs[3], 1'b1);
    drive_window(vecs[7], 1'b1);

    check("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
